// File: rtl/gmux_seq_pkg.sv
// Shared types and constants for the global clock mux enable sequencer.
// Quadrant and switch FSM encodings, quadrant indices, counter sizing.
package gmux_seq_pkg;

  typedef enum logic [2:0] {
    OFF,
    WAKE,
    ARM,
    ON,
    DRAIN,
    DISARM
  } quad_state_e;

  typedef enum logic [2:0] {
    SW_IDLE,
    SW_QUIESCE,
    SW_PRE,
    SW_FLIP,
    SW_POST,
    SW_ACK
  } sw_state_e;

  localparam int unsigned TL = 0;
  localparam int unsigned TR = 1;
  localparam int unsigned BL = 2;
  localparam int unsigned BR = 3;

  function automatic int unsigned cnt_width(input int unsigned wake, input int unsigned settle);
    int unsigned m;
    m = (wake > settle) ? wake : settle;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gmux_quad_fsm.sv
// One quadrant's enable sequencer: OFF->WAKE->ARM->ON->DRAIN->DISARM->OFF.
// Every output is a flop loaded from the next state.
module gmux_quad_fsm
  import gmux_seq_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = cnt_width(WAKE_CYCLES, SETTLE_CYCLES)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_req,
  input  logic i_hold,
  output logic o_vlp,
  output logic o_dynen,
  output logic o_den,
  output logic o_on,
  output logic o_waking,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] WAKE_LD   = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  quad_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_dec;
  logic             r_held, w_held_nxt;
  logic             r_vlp, r_dynen, r_den, r_on, r_waking, r_busy;

  assign w_cnt_dec = r_cnt - CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_held_nxt  = r_held;
    case (r_state)
      OFF: begin
        if (i_req) begin
          w_state_nxt = WAKE;
          w_cnt_nxt   = WAKE_LD;
        end
      end
      WAKE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ARM;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      ARM: begin
        if (r_cnt == '0) w_state_nxt = ON;
        else             w_cnt_nxt   = w_cnt_dec;
      end
      ON: begin
        if (!i_req) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = SETTLE_LD;
          w_held_nxt  = i_hold;
        end
      end
      DRAIN: begin
        // A drain started by a source switch parks here; on release it may
        // jump straight back to ON without a full power cycle.
        if (r_held && i_hold) begin
          w_cnt_nxt = (r_cnt == '0) ? '0 : w_cnt_dec;
        end else if (r_held && i_req) begin
          w_state_nxt = ON;
          w_held_nxt  = 1'b0;
        end else if (r_cnt == '0) begin
          w_state_nxt = DISARM;
          w_cnt_nxt   = SETTLE_LD;
          w_held_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      DISARM: begin
        if (r_cnt == '0) w_state_nxt = OFF;
        else             w_cnt_nxt   = w_cnt_dec;
      end
      default: w_state_nxt = OFF;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= OFF;
      r_cnt    <= '0;
      r_held   <= 1'b0;
      r_vlp    <= 1'b1;
      r_dynen  <= 1'b0;
      r_den    <= 1'b0;
      r_on     <= 1'b0;
      r_waking <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_held   <= w_held_nxt;
      r_vlp    <= (w_state_nxt == OFF);
      r_dynen  <= (w_state_nxt inside {ARM, ON, DRAIN});
      r_den    <= (w_state_nxt == ON);
      r_on     <= (w_state_nxt == ON);
      r_waking <= (w_state_nxt inside {WAKE, ARM});
      r_busy   <= !(w_state_nxt inside {OFF, ON});
    end
  end

  assign o_vlp    = r_vlp;
  assign o_dynen  = r_dynen;
  assign o_den    = r_den;
  assign o_on     = r_on;
  assign o_waking = r_waking;
  assign o_busy   = r_busy;

endmodule

// File: rtl/gmux_quad_en_seq.sv
// Global clock mux sequencer: four quadrant enable FSMs plus a source-switch
// FSM that quiesces all quadrants around an SSEL change.
module gmux_quad_en_seq
  import gmux_seq_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  SEN_MASK      = 4'b1111
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] QEN_REQ,
  input  logic       SSEL_VALID,
  input  logic       SSEL_NEW,
  output logic       SSEL_READY,
  output logic       SSEL_ACK,
  output logic       SSEL,
  output logic       TL_SEN,
  output logic       TR_SEN,
  output logic       BL_SEN,
  output logic       BR_SEN,
  output logic       TL_DEN,
  output logic       TR_DEN,
  output logic       BL_DEN,
  output logic       BR_DEN,
  output logic       TL_DYNEN,
  output logic       TR_DYNEN,
  output logic       BL_DYNEN,
  output logic       BR_DYNEN,
  output logic       TL_VLP,
  output logic       TR_VLP,
  output logic       BL_VLP,
  output logic       BR_VLP,
  output logic [3:0] Q_ON,
  output logic       BUSY
);

  localparam int unsigned      CNT_W     = cnt_width(WAKE_CYCLES, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  sw_state_e        r_sw, w_sw_nxt;
  logic [CNT_W-1:0] r_sw_cnt, w_sw_cnt_nxt, w_sw_cnt_dec;
  logic             r_ovr, r_ssel, r_ack, r_ready, r_sw_busy;
  logic [3:0]       w_eff_req;
  logic [3:0]       w_vlp, w_dynen, w_den, w_on, w_waking, w_busy;
  logic             w_quiet;

  assign w_eff_req    = QEN_REQ & ~{4{r_ovr}};
  assign w_quiet      = ~|w_den & ~|w_waking;
  assign w_sw_cnt_dec = r_sw_cnt - CNT_W'(1);

  for (genvar g = 0; g < 4; g++) begin : g_quad
    gmux_quad_fsm #(
      .WAKE_CYCLES  (WAKE_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_quad (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_req   (w_eff_req[g]),
      .i_hold  (r_ovr),
      .o_vlp   (w_vlp[g]),
      .o_dynen (w_dynen[g]),
      .o_den   (w_den[g]),
      .o_on    (w_on[g]),
      .o_waking(w_waking[g]),
      .o_busy  (w_busy[g])
    );
  end

  always_comb begin
    w_sw_nxt     = r_sw;
    w_sw_cnt_nxt = r_sw_cnt;
    case (r_sw)
      SW_IDLE: begin
        if (SSEL_VALID && r_ready) begin
          if (SSEL_NEW == r_ssel) begin
            w_sw_nxt     = SW_ACK;
            w_sw_cnt_nxt = '0;
          end else begin
            w_sw_nxt = SW_QUIESCE;
          end
        end
      end
      SW_QUIESCE: begin
        if (w_quiet) begin
          w_sw_nxt     = SW_PRE;
          w_sw_cnt_nxt = SETTLE_LD;
        end
      end
      SW_PRE: begin
        if (r_sw_cnt == '0) w_sw_nxt     = SW_FLIP;
        else                w_sw_cnt_nxt = w_sw_cnt_dec;
      end
      SW_FLIP: begin
        w_sw_nxt     = SW_POST;
        w_sw_cnt_nxt = SETTLE_LD;
      end
      SW_POST: begin
        // One extra ACK cycle lets held quadrants re-enable before the pulse.
        if (r_sw_cnt == '0) begin
          w_sw_nxt     = SW_ACK;
          w_sw_cnt_nxt = CNT_W'(1);
        end else begin
          w_sw_cnt_nxt = w_sw_cnt_dec;
        end
      end
      SW_ACK: begin
        if (r_sw_cnt == '0) w_sw_nxt     = SW_IDLE;
        else                w_sw_cnt_nxt = w_sw_cnt_dec;
      end
      default: w_sw_nxt = SW_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sw      <= SW_IDLE;
      r_sw_cnt  <= '0;
      r_ovr     <= 1'b0;
      r_ssel    <= 1'b0;
      r_ack     <= 1'b0;
      r_ready   <= 1'b0;
      r_sw_busy <= 1'b0;
    end else begin
      r_sw      <= w_sw_nxt;
      r_sw_cnt  <= w_sw_cnt_nxt;
      r_ovr     <= (w_sw_nxt inside {SW_QUIESCE, SW_PRE, SW_FLIP, SW_POST});
      r_ack     <= (w_sw_nxt == SW_ACK) && (w_sw_cnt_nxt == '0);
      r_ready   <= (w_sw_nxt == SW_IDLE);
      r_sw_busy <= (w_sw_nxt inside {SW_QUIESCE, SW_PRE, SW_FLIP, SW_POST});
      if (r_sw == SW_PRE && w_sw_nxt == SW_FLIP) r_ssel <= ~r_ssel;
    end
  end

  assign SSEL_READY = r_ready;
  assign SSEL_ACK   = r_ack;
  assign SSEL       = r_ssel;
  assign BUSY       = r_sw_busy | (|w_busy);
  assign Q_ON       = w_on;

  assign TL_SEN = SEN_MASK[TL];
  assign TR_SEN = SEN_MASK[TR];
  assign BL_SEN = SEN_MASK[BL];
  assign BR_SEN = SEN_MASK[BR];

  assign TL_DEN = w_den[TL];
  assign TR_DEN = w_den[TR];
  assign BL_DEN = w_den[BL];
  assign BR_DEN = w_den[BR];

  assign TL_DYNEN = w_dynen[TL];
  assign TR_DYNEN = w_dynen[TR];
  assign BL_DYNEN = w_dynen[BL];
  assign BR_DYNEN = w_dynen[BR];

  assign TL_VLP = w_vlp[TL];
  assign TR_VLP = w_vlp[TR];
  assign BL_VLP = w_vlp[BL];
  assign BR_VLP = w_vlp[BR];

endmodule
